// File: rtl/game_pkg.sv
// Shared definitions for the player life tracking logic: FSM state
// encoding and default sprite / life sizes.
package game_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE    = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_DEAD     = 2'd2
   } state_t;

   localparam int DEF_SPR_W    = 4;
   localparam int DEF_SPR_H    = 4;
   localparam int DEF_MAX_LIFE = 3;

endpackage

// File: rtl/sprite_overlap.sv
// Combinational axis-aligned bounding-box test between the player sprite
// and one fireball sprite. Sums are formed one bit wider than the
// coordinates so sprites at the right/bottom edge never wrap to zero.
module sprite_overlap #(
   parameter int X_W   = 7,
   parameter int Y_W   = 6,
   parameter int SPR_W = 4,
   parameter int SPR_H = 4
) (
   input  logic [X_W-1:0] char_x,
   input  logic [Y_W-1:0] char_y,
   input  logic [X_W-1:0] fire_x,
   input  logic [Y_W-1:0] fire_y,
   input  logic           valid,
   output logic           hit
);

   logic [X_W:0] char_x_end;
   logic [X_W:0] fire_x_end;
   logic [Y_W:0] char_y_end;
   logic [Y_W:0] fire_y_end;
   logic         ovl_x;
   logic         ovl_y;

   assign char_x_end = {1'b0, char_x} + (X_W+1)'(SPR_W);
   assign fire_x_end = {1'b0, fire_x} + (X_W+1)'(SPR_W);
   assign char_y_end = {1'b0, char_y} + (Y_W+1)'(SPR_H);
   assign fire_y_end = {1'b0, fire_y} + (Y_W+1)'(SPR_H);

   assign ovl_x = (char_x_end > {1'b0, fire_x}) && (fire_x_end > {1'b0, char_x});
   assign ovl_y = (char_y_end > {1'b0, fire_y}) && (fire_y_end > {1'b0, char_y});

   assign hit = valid && ovl_x && ovl_y;

endmodule

// File: rtl/life_tracker.sv
// Player life counter: checks the player against NUM_FIRE fireballs each
// cycle, takes a life on a hit, then holds a fixed invulnerability window.
// Heal pickups add a life up to MAX_LIFE; running out of lives latches a
// DEAD state that only restart (or reset) leaves. All outputs registered.
module life_tracker import game_pkg::*; #(
   parameter int NUM_FIRE  = 4,
   parameter int X_W       = 7,
   parameter int Y_W       = 6,
   parameter int SPR_W     = DEF_SPR_W,
   parameter int SPR_H     = DEF_SPR_H,
   parameter int MAX_LIFE  = DEF_MAX_LIFE,
   parameter int LIFE_W    = 2,
   parameter int CD_CYCLES = 8,
   parameter int CD_W      = 3
) (
   input  logic                    clk,
   input  logic                    clr_n,
   input  logic                    restart,
   input  logic                    heal,
   input  logic [X_W-1:0]          char_x,
   input  logic [Y_W-1:0]          char_y,
   input  logic [NUM_FIRE*X_W-1:0] fire_x,
   input  logic [NUM_FIRE*Y_W-1:0] fire_y,
   input  logic [NUM_FIRE-1:0]     fire_valid,
   output logic [LIFE_W-1:0]       life,
   output logic                    cooldown,
   output logic [CD_W-1:0]         cd_cnt,
   output logic                    hit_pulse,
   output logic [NUM_FIRE-1:0]     hit_mask,
   output logic                    game_over
);

   localparam logic [LIFE_W-1:0] LIFE_FULL = LIFE_W'(MAX_LIFE);
   localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(CD_CYCLES - 1);

   logic [NUM_FIRE-1:0] overlap;
   logic                any_hit;

   state_t              state, state_nx;
   logic [LIFE_W-1:0]   life_nx;
   logic                cooldown_nx;
   logic [CD_W-1:0]     cd_cnt_nx;
   logic                hit_pulse_nx;
   logic [NUM_FIRE-1:0] hit_mask_nx;
   logic                game_over_nx;

   for (genvar i = 0; i < NUM_FIRE; i++) begin : g_ovl
      sprite_overlap #(
         .X_W   (X_W),
         .Y_W   (Y_W),
         .SPR_W (SPR_W),
         .SPR_H (SPR_H)
      ) u_ovl (
         .char_x (char_x),
         .char_y (char_y),
         .fire_x (fire_x[i*X_W +: X_W]),
         .fire_y (fire_y[i*Y_W +: Y_W]),
         .valid  (fire_valid[i]),
         .hit    (overlap[i])
      );
   end

   assign any_hit = |overlap;

   // Next-state and next-output decode; restart beats hit, hit beats heal.
   always_comb begin
      state_nx     = state;
      life_nx      = life;
      cooldown_nx  = cooldown;
      cd_cnt_nx    = cd_cnt;
      hit_pulse_nx = 1'b0;
      hit_mask_nx  = hit_mask;
      game_over_nx = game_over;

      if (restart) begin
         state_nx     = ST_ALIVE;
         life_nx      = LIFE_FULL;
         cooldown_nx  = 1'b0;
         cd_cnt_nx    = '0;
         hit_mask_nx  = '0;
         game_over_nx = 1'b0;
      end else begin
         case (state)
            ST_ALIVE: begin
               if (any_hit) begin
                  hit_pulse_nx = 1'b1;
                  hit_mask_nx  = overlap;
                  if (life <= LIFE_W'(1)) begin
                     state_nx     = ST_DEAD;
                     life_nx      = '0;
                     game_over_nx = 1'b1;
                  end else begin
                     state_nx    = ST_COOLDOWN;
                     life_nx     = life - LIFE_W'(1);
                     cooldown_nx = 1'b1;
                     cd_cnt_nx   = '0;
                  end
               end else if (heal && (life < LIFE_FULL)) begin
                  life_nx = life + LIFE_W'(1);
               end
            end
            ST_COOLDOWN: begin
               if (cd_cnt == CD_LAST) begin
                  state_nx    = ST_ALIVE;
                  cooldown_nx = 1'b0;
                  cd_cnt_nx   = '0;
               end else begin
                  cd_cnt_nx = cd_cnt + CD_W'(1);
               end
               if (heal && (life < LIFE_FULL)) begin
                  life_nx = life + LIFE_W'(1);
               end
            end
            ST_DEAD: begin
               life_nx      = '0;
               game_over_nx = 1'b1;
            end
            default: begin
               state_nx = ST_ALIVE;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously by clr_n.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state     <= ST_ALIVE;
         life      <= LIFE_FULL;
         cooldown  <= 1'b0;
         cd_cnt    <= '0;
         hit_pulse <= 1'b0;
         hit_mask  <= '0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         life      <= life_nx;
         cooldown  <= cooldown_nx;
         cd_cnt    <= cd_cnt_nx;
         hit_pulse <= hit_pulse_nx;
         hit_mask  <= hit_mask_nx;
         game_over <= game_over_nx;
      end
   end

endmodule

// File: tb/tb_life_tracker.sv
// Directed bench for life_tracker with hand-computed expectations.
module tb_life_tracker;

   localparam int NF = 4;
   localparam int XW = 7;
   localparam int YW = 6;

   logic           clk;
   logic           clr_n;
   logic           restart;
   logic           heal;
   logic [XW-1:0]  char_x;
   logic [YW-1:0]  char_y;
   logic [NF*XW-1:0] fire_x;
   logic [NF*YW-1:0] fire_y;
   logic [NF-1:0]  fire_valid;
   logic [1:0]     life;
   logic           cooldown;
   logic [2:0]     cd_cnt;
   logic           hit_pulse;
   logic [NF-1:0]  hit_mask;
   logic           game_over;

   int n_cmp = 0;
   int n_bad = 0;

   life_tracker dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .restart    (restart),
      .heal       (heal),
      .char_x     (char_x),
      .char_y     (char_y),
      .fire_x     (fire_x),
      .fire_y     (fire_y),
      .fire_valid (fire_valid),
      .life       (life),
      .cooldown   (cooldown),
      .cd_cnt     (cd_cnt),
      .hit_pulse  (hit_pulse),
      .hit_mask   (hit_mask),
      .game_over  (game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fire(input int ch, input int x, input int y, input logic v);
      fire_x[ch*XW +: XW] = XW'(x);
      fire_y[ch*YW +: YW] = YW'(y);
      fire_valid[ch]      = v;
   endtask

   task automatic do_restart();
      fire_valid = '0;
      heal       = 1'b0;
      restart    = 1'b1;
      tick();
      restart    = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_life"}, 32'(life), 32'd3);
      chk({tag, "_cool"}, 32'(cooldown), 32'd0);
      chk({tag, "_cd"}, 32'(cd_cnt), 32'd0);
      chk({tag, "_pulse"}, 32'(hit_pulse), 32'd0);
      chk({tag, "_mask"}, 32'(hit_mask), 32'd0);
      chk({tag, "_over"}, 32'(game_over), 32'd0);
   endtask

   initial begin
      int pulses;
      clr_n      = 1'b0;
      restart    = 1'b0;
      heal       = 1'b0;
      char_x     = '0;
      char_y     = '0;
      fire_x     = '0;
      fire_y     = '0;
      fire_valid = '0;
      tick();
      tick();
      chk_reset_vals("rst");
      clr_n = 1'b1;
      tick();

      // Single hit by channel 0 and the full cooldown window.
      char_x = 7'd10;
      char_y = 6'd10;
      set_fire(0, 12, 11, 1'b1);
      tick();
      fire_valid = '0;
      chk("t1_life", 32'(life), 32'd2);
      chk("t1_pulse", 32'(hit_pulse), 32'd1);
      chk("t1_mask", 32'(hit_mask), 32'b0001);
      chk("t1_cool0", 32'(cooldown), 32'd1);
      chk("t1_cd0", 32'(cd_cnt), 32'd0);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("t1_cd%0d", k), 32'(cd_cnt), 32'(k));
         chk($sformatf("t1_cool%0d", k), 32'(cooldown), 32'd1);
         chk($sformatf("t1_pulse%0d", k), 32'(hit_pulse), 32'd0);
      end
      tick();
      chk("t1_cool_end", 32'(cooldown), 32'd0);
      chk("t1_cd_end", 32'(cd_cnt), 32'd0);
      chk("t1_life_end", 32'(life), 32'd2);
      chk("t1_mask_held", 32'(hit_mask), 32'b0001);

      // Continuous overlap: hits 9 cycles apart down to game over.
      do_restart();
      chk("t2_restart_life", 32'(life), 32'd3);
      set_fire(0, 10, 10, 1'b1);
      tick();
      chk("t2_hit1_life", 32'(life), 32'd2);
      chk("t2_hit1_pulse", 32'(hit_pulse), 32'd1);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         pulses += int'(hit_pulse);
      end
      chk("t2_gap1_pulses", 32'(pulses), 32'd0);
      tick();
      chk("t2_hit2_life", 32'(life), 32'd1);
      chk("t2_hit2_pulse", 32'(hit_pulse), 32'd1);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         pulses += int'(hit_pulse);
      end
      chk("t2_gap2_pulses", 32'(pulses), 32'd0);
      tick();
      chk("t2_hit3_life", 32'(life), 32'd0);
      chk("t2_hit3_pulse", 32'(hit_pulse), 32'd1);
      chk("t2_hit3_over", 32'(game_over), 32'd1);
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         heal = 1'b1;
         tick();
         pulses += int'(hit_pulse);
      end
      heal = 1'b0;
      chk("t2_dead_pulses", 32'(pulses), 32'd0);
      chk("t2_dead_life", 32'(life), 32'd0);
      chk("t2_dead_over", 32'(game_over), 32'd1);
      chk("t2_dead_cool", 32'(cooldown), 32'd0);
      do_restart();
      chk_reset_vals("t2_revive");

      // Coordinate edges: no wrap at the top of the x range.
      char_x = 7'd126;
      char_y = 6'd10;
      set_fire(0, 0, 10, 1'b1);
      tick();
      chk("t3_wrap_pulse", 32'(hit_pulse), 32'd0);
      chk("t3_wrap_life", 32'(life), 32'd3);
      char_x = 7'd0;
      set_fire(0, 3, 10, 1'b1);
      tick();
      fire_valid = '0;
      chk("t3_x3_pulse", 32'(hit_pulse), 32'd1);
      chk("t3_x3_life", 32'(life), 32'd2);
      for (int k = 0; k < 8; k++) tick();
      chk("t3_cd_done", 32'(cooldown), 32'd0);
      set_fire(0, 4, 10, 1'b1);
      tick();
      chk("t3_x4_pulse", 32'(hit_pulse), 32'd0);
      set_fire(0, 0, 10, 1'b0);
      tick();
      chk("t3_inval_pulse", 32'(hit_pulse), 32'd0);
      chk("t3_inval_life", 32'(life), 32'd2);

      // Heal saturation, heal during cooldown, heal dropped on hit.
      do_restart();
      heal = 1'b1;
      tick();
      heal = 1'b0;
      chk("t4_heal_sat", 32'(life), 32'd3);
      char_x = 7'd10;
      set_fire(0, 10, 10, 1'b1);
      tick();
      fire_valid = '0;
      chk("t4_hit_life", 32'(life), 32'd2);
      tick();
      tick();
      heal = 1'b1;
      tick();
      heal = 1'b0;
      chk("t4_heal_cd_life", 32'(life), 32'd3);
      chk("t4_heal_cd_cnt", 32'(cd_cnt), 32'd3);
      chk("t4_heal_cd_cool", 32'(cooldown), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      chk("t4_cd7", 32'(cd_cnt), 32'd7);
      chk("t4_cd7_cool", 32'(cooldown), 32'd1);
      tick();
      chk("t4_cd_end", 32'(cooldown), 32'd0);
      set_fire(0, 10, 10, 1'b1);
      tick();
      fire_valid = '0;
      chk("t4_pre_life", 32'(life), 32'd2);
      for (int k = 0; k < 8; k++) tick();
      chk("t4_pre_alive", 32'(cooldown), 32'd0);
      set_fire(0, 10, 10, 1'b1);
      heal = 1'b1;
      tick();
      heal = 1'b0;
      fire_valid = '0;
      chk("t4_both_life", 32'(life), 32'd1);
      chk("t4_both_pulse", 32'(hit_pulse), 32'd1);

      // Two channels at once, then async reset mid-cooldown.
      do_restart();
      char_x = 7'd10;
      char_y = 6'd10;
      set_fire(0, 40, 40, 1'b1);
      set_fire(1, 11, 10, 1'b1);
      set_fire(2, 10, 40, 1'b1);
      set_fire(3, 8, 12, 1'b1);
      tick();
      fire_valid = '0;
      chk("t5_life", 32'(life), 32'd2);
      chk("t5_mask", 32'(hit_mask), 32'b1010);
      chk("t5_pulse", 32'(hit_pulse), 32'd1);
      for (int k = 0; k < 4; k++) tick();
      chk("t6_cd4", 32'(cd_cnt), 32'd4);
      #2;
      clr_n = 1'b0;
      #1;
      chk_reset_vals("t6_async");
      tick();
      chk_reset_vals("t6_held");
      clr_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/life_tracker.md
Name: life_tracker

Overview:
- Parametrised successor to the player life counter: checks the player sprite against NUM_FIRE fireball sprites each clock.
- Decrements lives on a hit, then grants a fixed invulnerability window.
- Adds per-channel valid masking, heal pickups, a registered hit pulse with source mask, and a latched game-over state that only an explicit restart clears.
- Sits between the sprite position logic and the HUD/game-control FSM.

Parameters:
- NUM_FIRE, 4, number of fireball channels checked in parallel
- X_W, 7, width of all x coordinates
- Y_W, 6, width of all y coordinates
- SPR_W, 4, sprite width in pixels (same for player and fireball)
- SPR_H, 4, sprite height in pixels
- MAX_LIFE, 3, life value after reset/restart; heal saturates here
- LIFE_W, 2, width of life output; must hold MAX_LIFE
- CD_CYCLES, 8, invulnerability length in clk cycles (>=1)
- CD_W, 3, width of cd_cnt; must hold CD_CYCLES-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- clr_n  in  1  asynchronous active-low reset
- restart  in  1  synchronous restart pulse; revives from any state
- heal  in  1  single-cycle heal pickup pulse
- char_x  in  X_W  player top-left x
- char_y  in  Y_W  player top-left y
- fire_x  in  NUM_FIRE*X_W  packed fireball x; channel i at [i*X_W +: X_W]
- fire_y  in  NUM_FIRE*Y_W  packed fireball y, same packing
- fire_valid  in  NUM_FIRE  channel enable; invalid channels never hit
- life  out  LIFE_W  current lives
- cooldown  out  1  high while invulnerable
- cd_cnt  out  CD_W  cooldown progress counter
- hit_pulse  out  1  one-cycle pulse when a life is taken
- hit_mask  out  NUM_FIRE  channels overlapping at the accepted hit; held until next hit/restart
- game_over  out  1  high in DEAD state

Behaviour:
- Reset (clr_n low, async): state ALIVE, life=MAX_LIFE, cooldown=0, cd_cnt=0, hit_pulse=0, hit_mask=0, game_over=0.
- Overlap for channel i, computed at X_W+1 / Y_W+1 bits (no wrap):
  - char_x+SPR_W > fire_x[i] AND fire_x[i]+SPR_W > char_x
  - same test on y with SPR_H
  - AND fire_valid[i]
- any_hit = OR of all channel overlaps.
- FSM states: ALIVE, COOLDOWN, DEAD; all outputs registered.
- ALIVE, any_hit sampled at edge N: at that edge
  - life <= life-1
  - hit_pulse <= 1 for exactly one cycle
  - hit_mask <= overlap vector
  - if life was 1: life=0, go DEAD, game_over=1
  - otherwise: go COOLDOWN, cooldown=1, cd_cnt=0
- COOLDOWN:
  - overlaps ignored
  - cd_cnt increments each cycle
  - at the edge where cd_cnt==CD_CYCLES-1: go ALIVE, cooldown=0, cd_cnt=0
  - cooldown is therefore high exactly CD_CYCLES cycles
  - a hit can be accepted on the first ALIVE cycle
- DEAD:
  - life=0, game_over=1
  - hits and heal ignored; state held indefinitely
- cd_cnt is 0 whenever not in COOLDOWN.
- heal, in ALIVE or COOLDOWN:
  - life <= min(life+1, MAX_LIFE)
  - does not alter the cooldown timer
- Priority, highest first:
  1. clr_n
  2. restart: any state -> ALIVE, life=MAX_LIFE, cooldown/cd_cnt/hit_mask/game_over cleared, hit_pulse=0
  3. hit: if hit and heal coincide in ALIVE, the hit is applied and the heal is dropped
  4. heal
- Coordinates of 0 and of max value must not wrap in the compare; the widened add handles this.
- Reset asserted mid-cooldown or in DEAD returns immediately to reset values.

Decomposition:
- game_pkg (shared) holds:
  - FSM state encoding (ST_ALIVE, ST_COOLDOWN, ST_DEAD)
  - default sprite sizes SPR_W/SPR_H
  - MAX_LIFE default
- Sub-module sprite_overlap: one purely combinational AABB compare (params X_W, Y_W, SPR_W, SPR_H), instantiated NUM_FIRE times via generate.
- FSM, life arithmetic and counters stay in life_tracker.

Test Plan:
- Reset, then char=(10,10), fire0=(12,11) valid, others invalid, hold 1 cycle -> hit_pulse one cycle, hit_mask=0001, life 3->2, cooldown high 8 cycles, cd_cnt 0..7.
- Fireball held on player continuously -> life 3->2->1->0, hits spaced exactly 9 cycles apart; after third hit game_over=1, life stays 0 while overlap persists; restart -> life=3, game_over=0.
- Edge/wrap check:
  - char_x=126, fire_x=0 -> no hit
  - char_x=0, fire_x=3 -> hit
  - char_x=0, fire_x=4 -> no hit
  - fire_valid=0 with full overlap -> no hit
- Heal handling:
  - heal at life=3 -> stays 3
  - heal at life=2 during cooldown -> 3, cooldown timing unchanged
  - heal and hit same cycle in ALIVE at life=2 -> life=1, hit_pulse=1
- Two fireballs (ch1, ch3) overlap simultaneously -> single decrement, hit_mask=1010.
- Drop clr_n asynchronously mid-cooldown (cd_cnt=4) -> outputs reach reset values immediately, without waiting for a clk edge.
